alu_stimulus_checker: RTL and testbench

ALU_STIMULUS_CHECKER -- requirements
Module: alu_stimulus_checker

---
 rtl/alu_stimulus_checker_if.sv | 22 ++
 rtl/alu_stimulus_checker.sv | 104 ++++++++++
 tb/tb_alu_stimulus_checker.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_stimulus_checker_if.sv
// rtl/alu_stimulus_checker_if.sv - control, operand and result bundle between the ALU checker and its environment
interface alu_stimulus_checker_if;
    logic       start;
    logic       halt_on_err;
    logic [7:0] op_out;
    logic [7:0] res_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] first_fail;

    modport slave (
        input  start, halt_on_err, res_in,
        output op_out, busy, done, pass, err_count, first_fail
    );

    modport master (
        output start, halt_on_err, res_in,
        input  op_out, busy, done, pass, err_count, first_fail
    );
endinterface

// File: rtl/alu_stimulus_checker.sv
// rtl/alu_stimulus_checker.sv - sweeps all 256 operand pairs through an adder ALU and checks its results
module alu_stimulus_checker (
    input  logic                        clk,
    input  logic                        rst,
    alu_stimulus_checker_if.slave       bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [7:0] op_q, op_d;
    logic       op_vld_q, op_vld_d;
    logic [7:0] cmp_vec_q, cmp_vec_d;
    logic       cmp_vld_q, cmp_vld_d;
    logic [7:0] err_q, err_d;
    logic [7:0] ff_q, ff_d;

    logic [7:0] expected;
    logic       mismatch;
    logic       halt_now;

    // The ALU registers its result, so op_out and the compare stage form the two-edge pipeline.
    assign expected = {3'b000, {1'b0, cmp_vec_q[3:0]} + {1'b0, cmp_vec_q[7:4]}};
    assign mismatch = cmp_vld_q && (bus.res_in != expected);
    assign halt_now = mismatch && bus.halt_on_err;

    always_comb begin
        state_d   = state_q;
        op_d      = 8'h00;
        op_vld_d  = 1'b0;
        cmp_vec_d = op_q;
        cmp_vld_d = op_vld_q;
        err_d     = err_q;
        ff_d      = ff_q;

        if (mismatch) begin
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'h01;
            end
            if (err_q == 8'h00) begin
                ff_d = cmp_vec_q;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d   = S_RUN;
                    op_vld_d  = 1'b1;
                    cmp_vld_d = 1'b0;
                    err_d     = 8'h00;
                    ff_d      = 8'h00;
                end
            end
            S_RUN: begin
                if (halt_now) begin
                    state_d   = S_DONE;
                    cmp_vld_d = 1'b0;
                end else if (op_q == 8'hFF) begin
                    state_d = S_DRAIN;
                end else begin
                    op_d     = op_q + 8'h01;
                    op_vld_d = 1'b1;
                end
            end
            S_DRAIN: begin
                state_d   = S_DONE;
                cmp_vld_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 8'h00;
            op_vld_q  <= 1'b0;
            cmp_vec_q <= 8'h00;
            cmp_vld_q <= 1'b0;
            err_q     <= 8'h00;
            ff_q      <= 8'h00;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            op_vld_q  <= op_vld_d;
            cmp_vec_q <= cmp_vec_d;
            cmp_vld_q <= cmp_vld_d;
            err_q     <= err_d;
            ff_q      <= ff_d;
        end
    end

    assign bus.op_out     = op_q;
    assign bus.busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.pass       = (state_q == S_DONE) && (err_q == 8'h00);
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;
endmodule

// File: tb/tb_alu_stimulus_checker.sv
// tb/tb_alu_stimulus_checker.sv - directed sweeps against a registered adder model with injectable faults
module tb_alu_stimulus_checker;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   fault_mode;
    logic [7:0] alu_q;

    typedef struct packed {
        logic [7:0] op;
        logic       busy;
        logic       done;
    } cyc_t;

    typedef struct packed {
        logic [7:0] err;
        logic [7:0] ff;
        logic       pass;
    } res_t;

    cyc_t sb_q[$];
    res_t res_q[$];

    alu_stimulus_checker_if bif ();

    alu_stimulus_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] v, input int fm);
        logic [7:0] good;
        good = {3'b000, {1'b0, v[3:0]} + {1'b0, v[7:4]}};
        if (fm == 1) return good & 8'hEF;
        if (fm == 2) return 8'hFF;
        return good;
    endfunction

    always @(posedge clk) alu_q <= alu_f(bif.op_out, fault_mode);
    assign bif.res_in = alu_q;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference outcome of one sweep, derived from the ALU model and the fault mode.
    task automatic predict(input int fm, input logic halt, output logic [7:0] err,
                           output logic [7:0] ff, output int done_edge);
        logic [7:0] good;
        err = 8'h00;
        ff = 8'h00;
        done_edge = 257;
        for (int v = 0; v < 256; v++) begin
            good = {3'b000, {1'b0, v[3:0]} + {1'b0, v[7:4]}};
            if (alu_f(v[7:0], fm) != good) begin
                if (err == 8'h00) ff = v[7:0];
                if (err != 8'hFF) err = err + 8'h01;
                if (halt) begin
                    done_edge = v + 2;
                    break;
                end
            end
        end
    endtask

    task automatic run_sweep(input int fm, input logic halt, input int start_at, input int abort_at);
        logic [7:0] e_err, e_ff;
        int         done_edge;
        cyc_t       c;
        res_t       r;
        fault_mode = fm;
        bif.halt_on_err = halt;
        predict(fm, halt, e_err, e_ff, done_edge);
        for (int k = 0; k <= done_edge; k++) begin
            c.op   = (k < done_edge && k <= 255) ? k[7:0] : 8'h00;
            c.busy = (k < done_edge);
            c.done = (k == done_edge);
            sb_q.push_back(c);
        end
        res_q.push_back('{err: e_err, ff: e_ff, pass: (e_err == 8'h00)});
        bif.start = 1'b1;
        for (int k = 0; k <= done_edge; k++) begin
            @(posedge clk);
            #1;
            if (k == 0 || k == start_at) bif.start = 1'b0;
            c = sb_q.pop_front();
            check($sformatf("op_out@%0d", k), bif.op_out, c.op);
            check($sformatf("busy@%0d", k), {7'd0, bif.busy}, {7'd0, c.busy});
            check($sformatf("done@%0d", k), {7'd0, bif.done}, {7'd0, c.done});
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_op_out", bif.op_out, 8'h00);
                check("rst_busy", {7'd0, bif.busy}, 8'h00);
                check("rst_done", {7'd0, bif.done}, 8'h00);
                check("rst_pass", {7'd0, bif.pass}, 8'h00);
                check("rst_err_count", bif.err_count, 8'h00);
                check("rst_first_fail", bif.first_fail, 8'h00);
                rst = 1'b0;
                sb_q.delete();
                res_q.delete();
                return;
            end
            if (k + 1 == start_at) bif.start = 1'b1;
        end
        r = res_q.pop_front();
        check("err_count", bif.err_count, r.err);
        check("first_fail", bif.first_fail, r.ff);
        check("pass", {7'd0, bif.pass}, {7'd0, r.pass});
        repeat (3) @(posedge clk);
        #1;
        check("hold_err_count", bif.err_count, r.err);
        check("hold_first_fail", bif.first_fail, r.ff);
        check("hold_done", {7'd0, bif.done}, 8'h01);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        fault_mode = 0;
        rst = 1'b1;
        bif.start = 1'b0;
        bif.halt_on_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_op_out", bif.op_out, 8'h00);
        check("reset_busy", {7'd0, bif.busy}, 8'h00);
        check("reset_done", {7'd0, bif.done}, 8'h00);
        check("reset_pass", {7'd0, bif.pass}, 8'h00);
        check("reset_err_count", bif.err_count, 8'h00);
        check("reset_first_fail", bif.first_fail, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_sweep(0, 1'b0, -1, -1);
        run_sweep(1, 1'b0, -1, -1);
        check("model_fault_errs", bif.err_count, 8'd120);
        run_sweep(1, 1'b1, -1, -1);
        run_sweep(2, 1'b0, -1, -1);
        run_sweep(0, 1'b0, 50, -1);
        run_sweep(1, 1'b0, -1, 100);

        repeat (3) @(posedge clk);
        #1;
        check("idle_after_rst_busy", {7'd0, bif.busy}, 8'h00);
        check("idle_after_rst_done", {7'd0, bif.done}, 8'h00);
        check("idle_after_rst_op", bif.op_out, 8'h00);
        run_sweep(0, 1'b0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
